// File: rtl/lsu_sequencer.sv
// lsu_sequencer: one-at-a-time load/store sequencer between the CPU control
// FSM and a word-wide data memory. Word-aligns the address, performs sub-word
// stores as read-modify-write, sign/zero-extends loads and flags misaligned or
// illegal requests without touching memory. Exactly one done pulse per request.
//
// Ports: clk/rst (sync, active-high); req/we/option/addr/wdata request side;
// busy/done/err/load_data status side; mem_addr/mem_re/mem_we/mem_wdata/
// mem_rdata/mem_ready memory side. All outputs are registered.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a memory phase that waits
// TIMEOUT_CYCLES cycles without mem_ready (reported as err).
module lsu_sequencer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  option,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  opt_q, opt_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;   // only the low half is ever merged
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  // Parameter kept in the interface for both builds; referenced here so the
  // default build carries no dangling parameter.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  logic        bad_opt, misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext, rd_merged;

  // Request classification at acceptance.
  assign bad_opt    = (option > 3'd4);
  assign misaligned = ((option[2:1] == 2'b01) && addr[0]) ||
                      ((option == 3'd4) && (addr[1:0] != 2'b00));

  // Lane selection from the latched byte offset.
  assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (opt_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {24'h0, rd_byte};
      3'b010:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b011:  rd_ext = {16'h0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane.
  always_comb begin
    rd_merged = mem_rdata;
    if (opt_q[1]) begin
      if (off_q[1]) rd_merged[31:16] = wdata_q;
      else          rd_merged[15:0]  = wdata_q;
    end else begin
      rd_merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    opt_d       = opt_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          opt_d      = option;
          off_d      = addr[1:0];
          wdata_d    = wdata[15:0];
          mem_addr_d = {addr[31:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
          cnt_d      = '0;
`endif
          if (bad_opt || misaligned) begin
            state_d = S_ERR;
          end else if (we && (option == 3'd4)) begin
            mem_wdata_d = wdata;
            state_d     = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        if (mem_ready) begin
          if (we_q) begin
            mem_wdata_d = rd_merged;
            state_d     = S_WR;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            load_data_d = rd_ext;
            state_d     = S_DONE;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT_CYCLES)) state_d = S_ERR;
        end
`endif
      end

      S_WR: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT_CYCLES)) state_d = S_ERR;
        end
`endif
      end

      // Error requests pass through DONE so busy stays high for the pulse.
      S_ERR:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so strobes align with the state.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_DONE) && (state_q == S_ERR);
    mem_re_d = (state_d == S_RD);
    mem_we_d = (state_d == S_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      opt_q       <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      opt_q       <= opt_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a small word memory model whose
// ready can be delayed by a programmable number of wait cycles.
module tb_lsu_sequencer;

  logic        clk, rst, req, we;
  logic [2:0]  option;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ready;

  int total = 0;
  int bad   = 0;
  int both_seen = 0;

  lsu_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .option(option),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: words at 0x100.. indexed by mem_addr[5:2].
  logic [31:0] mem [0:15];
  logic        preload;
  int          stall_n = 0;
  int          wait_cnt = 0;

  assign mem_ready = (mem_re || mem_we) && (wait_cnt >= stall_n);
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899AABB;   // 0x100
      mem[2] <= 32'h11223344;   // 0x108
    end else if (mem_we && mem_ready) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
    if (!(mem_re || mem_we) || mem_ready) wait_cnt <= 0;
    else                                  wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request so it is accepted at the next rising edge (E0).
  task automatic issue(input logic w, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; option = o; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // Samples each cycle from E0-E1 (lat 0) until done; bounded.
  task automatic wait_done(output int lat, output logic e, output int rc,
                           output int wc, output logic [31:0] a0);
    bit found = 0;
    lat = -1; e = 1'b0; rc = 0; wc = 0; a0 = 32'h0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) a0 = mem_addr;
      rc += int'(mem_re);
      wc += int'(mem_we);
      if (mem_re && mem_we) both_seen++;
      if (done) begin
        lat = i; e = err; found = 1;
        break;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic w, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input logic exp_err,
                     input int exp_rc, input int exp_wc);
    int lat, rc, wc;
    logic e;
    logic [31:0] a0;
    issue(w, o, a, d);
    wait_done(lat, e, rc, wc, a0);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
    chk({tag, "_rd"},  rc, exp_rc);
    chk({tag, "_wr"},  wc, exp_wc);
    if (!exp_err) chk({tag, "_addr"}, a0, {a[31:2], 2'b00});
  endtask

  initial begin
    int lat, rc, wc, dn;
    logic e;
    logic [31:0] a0;

    rst = 1'b1; preload = 1'b1; req = 1'b0; we = 1'b0;
    option = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err",  {31'h0, err},  32'h0);
    chk("rst_ld",   load_data, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_strb", {30'h0, mem_re, mem_we}, 32'h0);
    chk("rst_wdat", mem_wdata, 32'h0);
    rst = 1'b0; preload = 1'b0;

    // Loads from 0x8899AABB.
    run("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 1, 0);
    chk("lb103_data", load_data, 32'hFFFFFF88);
    run("lhu102", 1'b0, 3'b011, 32'h102, 32'h0, 1, 1'b0, 1, 0);
    chk("lhu102_data", load_data, 32'h00008899);
    run("lh100",  1'b0, 3'b010, 32'h100, 32'h0, 1, 1'b0, 1, 0);
    chk("lh100_data", load_data, 32'hFFFFAABB);
    run("lbu101", 1'b0, 3'b001, 32'h101, 32'h0, 1, 1'b0, 1, 0);
    chk("lbu101_data", load_data, 32'h000000AA);

    // Byte store: one read then one write.
    run("sb101", 1'b1, 3'b000, 32'h101, 32'h0000005A, 2, 1'b0, 1, 1);
    chk("sb101_mem", mem[0], 32'h88995ABB);
    run("lw100", 1'b0, 3'b100, 32'h100, 32'h0, 1, 1'b0, 1, 0);
    chk("lw100_data", load_data, 32'h88995ABB);

    // Half store into upper lane, word store with no read.
    run("sh106", 1'b1, 3'b010, 32'h106, 32'hFFFFBEEF, 2, 1'b0, 1, 1);
    chk("sh106_mem", mem[1], 32'hBEEF0000);
    run("sw104", 1'b1, 3'b100, 32'h104, 32'h12345678, 1, 1'b0, 0, 1);
    chk("sw104_mem", mem[1], 32'h12345678);

    // Error paths: no strobes, load_data untouched.
    run("lw102_mis", 1'b0, 3'b100, 32'h102, 32'h0, 1, 1'b1, 0, 0);
    chk("lw102_ld_keep", load_data, 32'h88995ABB);
    run("lh101_mis", 1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b1, 0, 0);
    run("opt101",    1'b0, 3'b101, 32'h100, 32'h0, 1, 1'b1, 0, 0);
    run("sw10a_mis", 1'b1, 3'b100, 32'h10A, 32'h0, 1, 1'b1, 0, 0);
    chk("sw10a_mem", mem[2], 32'h11223344);

    // Three wait cycles on a load.
    stall_n = 3;
    run("lb_wait3", 1'b0, 3'b000, 32'h104, 32'h0, 4, 1'b0, 4, 0);
    chk("lb_wait3_data", load_data, 32'h00000078);
    stall_n = 0;

    // Memory that never answers.
    stall_n = 1000;
`ifdef LSU_TIMEOUT_EN
    run("tmo", 1'b0, 3'b100, 32'h100, 32'h0, 17, 1'b1, 16, 0);
    chk("tmo_ld_keep", load_data, 32'h00000078);
    stall_n = 0;
`else
    issue(1'b0, 3'b100, 32'h100, 32'h0);
    repeat (20) @(negedge clk);
    chk("hang_busy", {31'h0, busy}, 32'h1);
    chk("hang_re",   {31'h0, mem_re}, 32'h1);
    stall_n = 0;
    wait_done(lat, e, rc, wc, a0);
    chk("hang_release_err", {31'h0, e}, 32'h0);
    chk("hang_release_data", load_data, 32'h88995ABB);
`endif

    // Reset during the write phase of a byte store.
    issue(1'b1, 3'b000, 32'h108, 32'h000000EE);
    @(negedge clk);               // RD, ready granted at E1
    @(negedge clk);               // WR
    stall_n = 1000;
    chk("rstmid_we_pre", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_we", {31'h0, mem_we}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    dn = int'(done);
    repeat (4) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("rstmid_no_done", dn, 0);
    chk("rstmid_mem", mem[2], 32'h11223344);
    chk("rstmid_ld", load_data, 32'h0);
    stall_n = 0;
    run("post_rst_lw", 1'b0, 3'b100, 32'h108, 32'h0, 1, 1'b0, 1, 0);
    chk("post_rst_data", load_data, 32'h11223344);

    chk("never_both_strobes", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
